// File: rtl/ift_mem_xbar.sv
// ift_mem_xbar: taint-tracking N-port round-robin router to an SRAM window and MMIO, fixed-latency in-order responses.
// Optional MEM_XBAR_OOB_ERR_EN: addresses above the SRAM window are answered locally with err_o instead of reaching MMIO.
module ift_mem_xbar #(
  parameter int unsigned          NumPorts    = 2,
  parameter int unsigned          AddrWidth   = 32,
  parameter int unsigned          DataWidth   = 64,
  parameter logic [AddrWidth-1:0] SramBase    = 32'h8000_0000,
  parameter logic [AddrWidth-1:0] SramBytes   = 32'h0080_0000,
  parameter int unsigned          RespLatency = 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NumPorts-1:0]             req_i,
  input  logic [NumPorts-1:0]             req_i_t0,
  input  logic [NumPorts-1:0]             we_i,
  input  logic [NumPorts-1:0]             we_i_t0,
  input  logic [NumPorts*AddrWidth-1:0]   addr_i,
  input  logic [NumPorts*AddrWidth-1:0]   addr_i_t0,
  input  logic [NumPorts*DataWidth-1:0]   wdata_i,
  input  logic [NumPorts*DataWidth-1:0]   wdata_i_t0,
  input  logic [NumPorts*DataWidth/8-1:0] strb_i,
  input  logic [NumPorts*DataWidth/8-1:0] strb_i_t0,
  output logic [NumPorts-1:0]             gnt_o,
  output logic [NumPorts-1:0]             gnt_o_t0,
  output logic [NumPorts-1:0]             rvalid_o,
  output logic [NumPorts-1:0]             rvalid_o_t0,
  output logic [NumPorts*DataWidth-1:0]   rdata_o,
  output logic [NumPorts*DataWidth-1:0]   rdata_o_t0,
  output logic [NumPorts-1:0]             err_o,
  output logic                            sram_req_o,
  output logic                            sram_req_o_t0,
  output logic                            sram_we_o,
  output logic                            sram_we_o_t0,
  output logic [AddrWidth-1:0]            sram_addr_o,
  output logic [AddrWidth-1:0]            sram_addr_o_t0,
  output logic [DataWidth-1:0]            sram_wdata_o,
  output logic [DataWidth-1:0]            sram_wdata_o_t0,
  output logic [DataWidth-1:0]            sram_wmask_o,
  output logic [DataWidth-1:0]            sram_wmask_o_t0,
  input  logic [DataWidth-1:0]            sram_rdata_i,
  input  logic [DataWidth-1:0]            sram_rdata_i_t0,
  output logic                            mmio_req_o,
  output logic                            mmio_req_o_t0,
  output logic                            mmio_we_o,
  output logic                            mmio_we_o_t0,
  output logic [AddrWidth-1:0]            mmio_addr_o,
  output logic [AddrWidth-1:0]            mmio_addr_o_t0,
  output logic [DataWidth-1:0]            mmio_wdata_o,
  output logic [DataWidth-1:0]            mmio_wdata_o_t0,
  output logic [DataWidth/8-1:0]          mmio_strb_o,
  output logic [DataWidth/8-1:0]          mmio_strb_o_t0,
  input  logic [DataWidth-1:0]            mmio_rdata_i,
  input  logic [DataWidth-1:0]            mmio_rdata_i_t0
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned IdW       = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int unsigned ByteShift = $clog2(StrbWidth);
  localparam logic [AddrWidth:0] SramEnd = {1'b0, SramBase} + {1'b0, SramBytes};

  typedef enum logic {
    TGT_SRAM = 1'b0,
    TGT_MMIO = 1'b1
  } tgt_e;

  typedef struct packed {
    logic           valid;
    logic [IdW-1:0] id;
    tgt_e           tgt;
    logic           we;
    logic           oob;
    logic           addr_taint;
    logic           gnt_t0;
  } resp_t;

  logic [IdW-1:0] ptr_q, ptr_d;
  resp_t          pipe_q [RespLatency];
  resp_t          pipe_d [RespLatency];
  resp_t          resp;

  logic                 gnt_valid;
  logic [IdW-1:0]       gnt_id;
  logic [IdW-1:0]       cand;
  logic                 arb_taint;
  logic                 sel_req_t0, sel_we, sel_we_t0;
  logic [AddrWidth-1:0] sel_addr, sel_addr_t0;
  logic [DataWidth-1:0] sel_wdata, sel_wdata_t0;
  logic [StrbWidth-1:0] sel_strb, sel_strb_t0;
  logic                 sel_hit, sel_oob;
  logic [DataWidth-1:0] resp_rdata, resp_rdata_t0;

  // Round-robin search starting at ptr_q; reset suppresses any grant.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NumPorts; k++) begin
      cand = IdW'((32'(ptr_q) + k) % NumPorts);
      if (!gnt_valid && req_i[cand] && !rst_i) begin
        gnt_valid = 1'b1;
        gnt_id    = cand;
      end
    end
    ptr_d = gnt_valid ? IdW'((32'(gnt_id) + 32'd1) % NumPorts) : ptr_q;
  end

  assign arb_taint    = |(req_i & req_i_t0);
  assign sel_req_t0   = req_i_t0[gnt_id];
  assign sel_we       = we_i[gnt_id];
  assign sel_we_t0    = we_i_t0[gnt_id];
  assign sel_addr     = addr_i[gnt_id*AddrWidth +: AddrWidth];
  assign sel_addr_t0  = addr_i_t0[gnt_id*AddrWidth +: AddrWidth];
  assign sel_wdata    = wdata_i[gnt_id*DataWidth +: DataWidth];
  assign sel_wdata_t0 = wdata_i_t0[gnt_id*DataWidth +: DataWidth];
  assign sel_strb     = strb_i[gnt_id*StrbWidth +: StrbWidth];
  assign sel_strb_t0  = strb_i_t0[gnt_id*StrbWidth +: StrbWidth];

  assign sel_hit = (sel_addr >= SramBase) && ({1'b0, sel_addr} < SramEnd);
`ifdef MEM_XBAR_OOB_ERR_EN
  assign sel_oob = !sel_hit && ({1'b0, sel_addr} >= SramEnd);
`else
  assign sel_oob = 1'b0;
`endif

  always_comb begin
    gnt_o    = '0;
    gnt_o_t0 = '0;
    if (gnt_valid) begin
      gnt_o[gnt_id]    = 1'b1;
      gnt_o_t0[gnt_id] = arb_taint;
    end
  end

  always_comb begin
    sram_req_o      = 1'b0;
    sram_req_o_t0   = 1'b0;
    sram_we_o       = 1'b0;
    sram_we_o_t0    = 1'b0;
    sram_addr_o     = '0;
    sram_addr_o_t0  = '0;
    sram_wdata_o    = '0;
    sram_wdata_o_t0 = '0;
    sram_wmask_o    = '0;
    sram_wmask_o_t0 = '0;
    mmio_req_o      = 1'b0;
    mmio_req_o_t0   = 1'b0;
    mmio_we_o       = 1'b0;
    mmio_we_o_t0    = 1'b0;
    mmio_addr_o     = '0;
    mmio_addr_o_t0  = '0;
    mmio_wdata_o    = '0;
    mmio_wdata_o_t0 = '0;
    mmio_strb_o     = '0;
    mmio_strb_o_t0  = '0;
    if (gnt_valid && !sel_oob) begin
      if (sel_hit) begin
        sram_req_o      = 1'b1;
        sram_req_o_t0   = sel_req_t0;
        sram_we_o       = sel_we;
        sram_we_o_t0    = sel_we_t0;
        sram_addr_o     = (sel_addr - SramBase) >> ByteShift;
        sram_addr_o_t0  = sel_addr_t0;
        sram_wdata_o    = sel_wdata;
        sram_wdata_o_t0 = sel_wdata_t0;
        for (int unsigned b = 0; b < StrbWidth; b++) begin
          sram_wmask_o[b*8 +: 8]    = {8{sel_strb[b]}};
          sram_wmask_o_t0[b*8 +: 8] = {8{sel_strb_t0[b]}};
        end
      end else begin
        mmio_req_o      = 1'b1;
        mmio_req_o_t0   = sel_req_t0;
        mmio_we_o       = sel_we;
        mmio_we_o_t0    = sel_we_t0;
        mmio_addr_o     = sel_addr;
        mmio_addr_o_t0  = sel_addr_t0;
        mmio_wdata_o    = sel_wdata;
        mmio_wdata_o_t0 = sel_wdata_t0;
        mmio_strb_o     = sel_strb;
        mmio_strb_o_t0  = sel_strb_t0;
      end
    end
  end

  always_comb begin
    pipe_d[0] = '0;
    if (gnt_valid) begin
      pipe_d[0].valid      = 1'b1;
      pipe_d[0].id         = gnt_id;
      pipe_d[0].tgt        = sel_hit ? TGT_SRAM : TGT_MMIO;
      pipe_d[0].we         = sel_we;
      pipe_d[0].oob        = sel_oob;
      pipe_d[0].addr_taint = |sel_addr_t0;
      pipe_d[0].gnt_t0     = arb_taint;
    end
    for (int unsigned s = 1; s < RespLatency; s++) begin
      pipe_d[s] = pipe_q[s-1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      for (int unsigned s = 0; s < RespLatency; s++) begin
        pipe_q[s] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      for (int unsigned s = 0; s < RespLatency; s++) begin
        pipe_q[s] <= pipe_d[s];
      end
    end
  end

  assign resp          = pipe_q[RespLatency-1];
  assign resp_rdata    = (resp.tgt == TGT_SRAM) ? sram_rdata_i    : mmio_rdata_i;
  assign resp_rdata_t0 = (resp.tgt == TGT_SRAM) ? sram_rdata_i_t0 : mmio_rdata_i_t0;

  // A tainted address taints the whole response word, including writes and OOB replies.
  always_comb begin
    rvalid_o    = '0;
    rvalid_o_t0 = '0;
    rdata_o     = '0;
    rdata_o_t0  = '0;
    err_o       = '0;
    if (resp.valid) begin
      rvalid_o[resp.id]    = 1'b1;
      rvalid_o_t0[resp.id] = resp.gnt_t0;
`ifdef MEM_XBAR_OOB_ERR_EN
      err_o[resp.id]       = resp.oob;
`endif
      if (!resp.we && !resp.oob) begin
        rdata_o[resp.id*DataWidth +: DataWidth]    = resp_rdata;
        rdata_o_t0[resp.id*DataWidth +: DataWidth] = resp_rdata_t0;
      end
      if (resp.addr_taint) begin
        rdata_o_t0[resp.id*DataWidth +: DataWidth] = '1;
      end
    end
  end

endmodule

// File: tb/tb_ift_mem_xbar.sv
// Scoreboard bench for ift_mem_xbar (2 ports, 64-bit data, latency 1); directed vectors, monitor-side response checking.
module tb_ift_mem_xbar;

  localparam logic [63:0] SRAM_RD   = 64'h1111_2222_3333_4444;
  localparam logic [63:0] MMIO_RD   = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] TAINT_PAT = 64'h0000_00FF_0000_0F00;
`ifdef MEM_XBAR_OOB_ERR_EN
  localparam bit OOB = 1'b1;
`else
  localparam bit OOB = 1'b0;
`endif

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [1:0]   req_i, req_i_t0, we_i, we_i_t0;
  logic [63:0]  addr_i, addr_i_t0;
  logic [127:0] wdata_i, wdata_i_t0;
  logic [15:0]  strb_i, strb_i_t0;
  logic [1:0]   gnt_o, gnt_o_t0, rvalid_o, rvalid_o_t0, err_o;
  logic [127:0] rdata_o, rdata_o_t0;
  logic         sram_req_o, sram_req_o_t0, sram_we_o, sram_we_o_t0;
  logic [31:0]  sram_addr_o, sram_addr_o_t0;
  logic [63:0]  sram_wdata_o, sram_wdata_o_t0, sram_wmask_o, sram_wmask_o_t0;
  logic [63:0]  sram_rdata_i, sram_rdata_i_t0;
  logic         mmio_req_o, mmio_req_o_t0, mmio_we_o, mmio_we_o_t0;
  logic [31:0]  mmio_addr_o, mmio_addr_o_t0;
  logic [63:0]  mmio_wdata_o, mmio_wdata_o_t0;
  logic [7:0]   mmio_strb_o, mmio_strb_o_t0;
  logic [63:0]  mmio_rdata_i, mmio_rdata_i_t0;

  ift_mem_xbar #(
    .NumPorts(2), .AddrWidth(32), .DataWidth(64),
    .SramBase(32'h8000_0000), .SramBytes(32'h0080_0000), .RespLatency(1)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_i(req_i), .req_i_t0(req_i_t0), .we_i(we_i), .we_i_t0(we_i_t0),
    .addr_i(addr_i), .addr_i_t0(addr_i_t0), .wdata_i(wdata_i), .wdata_i_t0(wdata_i_t0),
    .strb_i(strb_i), .strb_i_t0(strb_i_t0),
    .gnt_o(gnt_o), .gnt_o_t0(gnt_o_t0), .rvalid_o(rvalid_o), .rvalid_o_t0(rvalid_o_t0),
    .rdata_o(rdata_o), .rdata_o_t0(rdata_o_t0), .err_o(err_o),
    .sram_req_o(sram_req_o), .sram_req_o_t0(sram_req_o_t0),
    .sram_we_o(sram_we_o), .sram_we_o_t0(sram_we_o_t0),
    .sram_addr_o(sram_addr_o), .sram_addr_o_t0(sram_addr_o_t0),
    .sram_wdata_o(sram_wdata_o), .sram_wdata_o_t0(sram_wdata_o_t0),
    .sram_wmask_o(sram_wmask_o), .sram_wmask_o_t0(sram_wmask_o_t0),
    .sram_rdata_i(sram_rdata_i), .sram_rdata_i_t0(sram_rdata_i_t0),
    .mmio_req_o(mmio_req_o), .mmio_req_o_t0(mmio_req_o_t0),
    .mmio_we_o(mmio_we_o), .mmio_we_o_t0(mmio_we_o_t0),
    .mmio_addr_o(mmio_addr_o), .mmio_addr_o_t0(mmio_addr_o_t0),
    .mmio_wdata_o(mmio_wdata_o), .mmio_wdata_o_t0(mmio_wdata_o_t0),
    .mmio_strb_o(mmio_strb_o), .mmio_strb_o_t0(mmio_strb_o_t0),
    .mmio_rdata_i(mmio_rdata_i), .mmio_rdata_i_t0(mmio_rdata_i_t0)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          port;
    logic [63:0] rdata;
    logic [63:0] rdata_t0;
    logic        err;
    logic        vt0;
  } exp_t;

  exp_t exp_q [$];
  int   n_cmp = 0;
  int   n_mis = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  task automatic push(input int p, input logic [63:0] d, input logic [63:0] dt, input logic e, input logic vt);
    exp_t x;
    x.port = p; x.rdata = d; x.rdata_t0 = dt; x.err = e; x.vt0 = vt;
    exp_q.push_back(x);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear();
    req_i = '0; req_i_t0 = '0; we_i = '0; we_i_t0 = '0;
    addr_i = '0; addr_i_t0 = '0; wdata_i = '0; wdata_i_t0 = '0;
    strb_i = '0; strb_i_t0 = '0;
  endtask

  task automatic set_req(input int p, input logic we, input logic [31:0] a,
                         input logic [63:0] wd, input logic [7:0] st);
    req_i[p]          = 1'b1;
    we_i[p]           = we;
    addr_i[p*32 +: 32] = a;
    wdata_i[p*64 +: 64] = wd;
    strb_i[p*8 +: 8]  = st;
  endtask

  task automatic do_reset();
    step();
    rst_i = 1'b1;
    clear();
    #1;
    chk("reset_rvalid", {62'b0, rvalid_o}, 64'd0);
    chk("reset_gnt", {62'b0, gnt_o}, 64'd0);
    step();
    step();
    rst_i = 1'b0;
  endtask

  task automatic rd0(input logic [31:0] a, input logic is_sram, input logic is_oob, input logic [31:0] idx);
    step();
    clear();
    set_req(0, 1'b0, a, 64'd0, 8'd0);
    #1;
    chk("rd_gnt", {62'b0, gnt_o}, 64'd1);
    chk("rd_gnt_t0", {62'b0, gnt_o_t0}, 64'd0);
    chk("rd_sram_req", {63'b0, sram_req_o}, {63'b0, is_sram});
    chk("rd_mmio_req", {63'b0, mmio_req_o}, {63'b0, !is_sram && !is_oob});
    if (is_sram) chk("rd_sram_addr", {32'b0, sram_addr_o}, {32'b0, idx});
    else if (!is_oob) chk("rd_mmio_addr", {32'b0, mmio_addr_o}, {32'b0, a});
    push(0, is_sram ? SRAM_RD : (is_oob ? 64'd0 : MMIO_RD), 64'd0, is_oob, 1'b0);
  endtask

  // Response monitor: every rvalid must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk_i);
      for (int p = 0; p < 2; p++) begin
        if (rvalid_o[p]) begin
          if (exp_q.size() == 0) begin
            chk("spurious_rvalid", {63'b0, rvalid_o[p]}, 64'd0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("resp_port", 64'(p), 64'(e.port));
            chk("resp_rdata", rdata_o[p*64 +: 64], e.rdata);
            chk("resp_rdata_t0", rdata_o_t0[p*64 +: 64], e.rdata_t0);
            chk("resp_err", {63'b0, err_o[p]}, {63'b0, e.err});
            chk("resp_rvalid_t0", {63'b0, rvalid_o_t0[p]}, {63'b0, e.vt0});
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 1'b1;
    clear();
    sram_rdata_i = SRAM_RD; sram_rdata_i_t0 = '0;
    mmio_rdata_i = MMIO_RD; mmio_rdata_i_t0 = '0;
    #1;
    chk("por_rvalid", {62'b0, rvalid_o}, 64'd0);
    chk("por_err", {62'b0, err_o}, 64'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    #1;
    chk("idle_sram_req", {63'b0, sram_req_o}, 64'd0);
    chk("idle_mmio_req", {63'b0, mmio_req_o}, 64'd0);

    // Decode vectors from port 0, including window edges and unaligned low bits.
    rd0(32'h8000_0010, 1'b1, 1'b0, 32'h0000_0002);
    rd0(32'h8000_0013, 1'b1, 1'b0, 32'h0000_0002);
    rd0(32'h807F_FFF8, 1'b1, 1'b0, 32'h000F_FFFF);
    rd0(32'h7FFF_FFF8, 1'b0, 1'b0, 32'h0);
    rd0(32'h1000_0000, 1'b0, 1'b0, 32'h0);
    rd0(32'h8080_0000, 1'b0, OOB,  32'h0);
    rd0(32'h9000_0000, 1'b0, OOB,  32'h0);
    step(); clear();
    do_reset();

    // Both ports every cycle: grants alternate starting at port 0.
    for (int c = 0; c < 4; c++) begin
      step(); clear();
      set_req(0, 1'b0, 32'h8000_0000, 64'd0, 8'd0);
      set_req(1, 1'b0, 32'h8000_0018, 64'd0, 8'd0);
      #1;
      chk("rr_gnt", {62'b0, gnt_o}, (c % 2 == 0) ? 64'd1 : 64'd2);
      chk("rr_sram_addr", {32'b0, sram_addr_o}, (c % 2 == 0) ? 64'd0 : 64'd3);
      push(c % 2, SRAM_RD, 64'd0, 1'b0, 1'b0);
    end
    step(); clear();
    do_reset();

    // Writes: SRAM byte mask expansion, then MMIO strobes pass through.
    step(); clear();
    set_req(0, 1'b1, 32'h8000_0000, 64'h0123_4567_89AB_CDEF, 8'h0F);
    #1;
    chk("wr_sram_we", {63'b0, sram_we_o}, 64'd1);
    chk("wr_sram_wmask", sram_wmask_o, 64'h0000_0000_FFFF_FFFF);
    chk("wr_sram_wdata", sram_wdata_o, 64'h0123_4567_89AB_CDEF);
    push(0, 64'd0, 64'd0, 1'b0, 1'b0);
    step(); clear();
    set_req(1, 1'b1, 32'h1000_0008, 64'hDEAD_BEEF_0000_1234, 8'hA5);
    #1;
    chk("wr_mmio_gnt", {62'b0, gnt_o}, 64'd2);
    chk("wr_mmio_we", {63'b0, mmio_we_o}, 64'd1);
    chk("wr_mmio_strb", {56'b0, mmio_strb_o}, 64'hA5);
    chk("wr_mmio_addr", {32'b0, mmio_addr_o}, 64'h1000_0008);
    chk("wr_mmio_sram_req", {63'b0, sram_req_o}, 64'd0);
    push(1, 64'd0, 64'd0, 1'b0, 1'b0);
    step(); clear();
    do_reset();

    // Taint: tainted request on the losing port taints the grant; tainted address forces rdata_t0.
    sram_rdata_i_t0 = TAINT_PAT;
    step(); clear();
    set_req(0, 1'b0, 32'h8000_0020, 64'd0, 8'd0);
    set_req(1, 1'b0, 32'h8000_0028, 64'd0, 8'd0);
    req_i_t0[1] = 1'b1;
    addr_i_t0[31:0] = 32'h0000_0004;
    #1;
    chk("taint_gnt", {62'b0, gnt_o}, 64'd1);
    chk("taint_gnt_t0", {62'b0, gnt_o_t0}, 64'd1);
    push(0, SRAM_RD, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    step(); clear();
    set_req(1, 1'b0, 32'h8000_0028, 64'd0, 8'd0);
    #1;
    chk("clean_gnt", {62'b0, gnt_o}, 64'd2);
    chk("clean_gnt_t0", {62'b0, gnt_o_t0}, 64'd0);
    push(1, SRAM_RD, TAINT_PAT, 1'b0, 1'b0);
    step(); clear();
    do_reset();
    sram_rdata_i_t0 = '0;

    // Reset while a read is in flight: the response must vanish.
    step(); clear();
    set_req(0, 1'b0, 32'h8000_0010, 64'd0, 8'd0);
    #1;
    chk("inflight_gnt", {62'b0, gnt_o}, 64'd1);
    step(); clear();
    rst_i = 1'b1;
    #1;
    chk("inflight_dropped", {62'b0, rvalid_o}, 64'd0);
    step(); step();
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_reset_rvalid", {62'b0, rvalid_o}, 64'd0);
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
